uart_rx_data_sampler: RTL

Upstream stage of the UART receive start-check and parity/stop-check logic. Synchronises the raw serial line and runs the oversampling edge counter and the bit counter. Takes three majority-voted samples around mid-bit and presents a registered SAMPLED_BIT plus a one-cycle SAMPLE_VALID strobe. The receive FSM uses this strobe to enable STRT_CHK_EN and the other checkers.

---
 rtl/uart_rx_data_sampler.sv | 87 ++++++++
 1 files changed

// File: rtl/uart_rx_data_sampler.sv
// UART receive data sampler: 2-FF line synchroniser, oversampling edge/bit
// counters and a 3-tap majority vote taken around mid-bit.
module uart_rx_data_sampler #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  ENABLE,
  input  logic                  DAT_SAMP_EN,
  output logic [PRESCALE_W-1:0] EDGE_CNT,
  output logic [BIT_CNT_W-1:0]  BIT_CNT,
  output logic                  SAMPLED_BIT,
  output logic                  SAMPLE_VALID
);

  logic [1:0]            sync_q;
  logic                  rx_s;
  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  s0_q, s0_d, s1_q, s1_d;
  logic                  bit_q, bit_d;
  logic                  vld_q, vld_d;
  logic [PRESCALE_W-1:0] half;
  logic                  maj;

  assign rx_s = sync_q[1];
  assign half = PRESCALE >> 1;
  assign maj  = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    bit_d      = bit_q;
    vld_d      = 1'b0;
    if (!ENABLE) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else begin
      // >= so a PRESCALE lowered below the current count wraps immediately
      if (edge_cnt_q >= PRESCALE - PRESCALE_W'(1)) begin
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + BIT_CNT_W'(1);
      end else begin
        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
      end
      if (DAT_SAMP_EN) begin
        if (edge_cnt_q == half - PRESCALE_W'(1)) s0_d = rx_s;
        if (edge_cnt_q == half)                  s1_d = rx_s;
        if (edge_cnt_q == half + PRESCALE_W'(1)) begin
          bit_d = maj;
          vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q     <= 2'b11;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      bit_q      <= 1'b1;
      vld_q      <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], RX_IN};
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      bit_q      <= bit_d;
      vld_q      <= vld_d;
    end
  end

  assign EDGE_CNT     = edge_cnt_q;
  assign BIT_CNT      = bit_cnt_q;
  assign SAMPLED_BIT  = bit_q;
  assign SAMPLE_VALID = vld_q;

endmodule
